sparse_pos_buffer: RTL
======================

// Module: sparse_pos_buffer
// PURPOSE
//  Parametrised successor to the single-port position RAM in front of the sparse polynomial multiplier.
//  Captures up to MAX_WEIGHT secret-vector positions and seals the set.
//  Pads the set with LFSR-generated dummy positions (flagged) to exactly MAX_WEIGHT entries, so multiply time is weight-independent.
//  Streams the entries to the multiplier core over a valid/ready handshake, starting at a pseudo-random rotation offset.
// PARAMETERS
//  MAX_WEIGHT  75        entries streamed per pass (real + dummy)
//  N           17669     polynomial length; every emitted position is < N
//  LOGW        15        position width; must satisfy N <= 2**LOGW <= 2*N and LOGW <= 16
//  DUMMY_EN    1         1: pad to MAX_WEIGHT; 0: no padding, stream count_o entries
//  SEED        16'hACE1  LFSR reset value; must be nonzero
//  LOGMW       clog2(MAX_WEIGHT+1)  counter width (derived)
// PORTS
//  clk         in   1      clock
//  rst_n       in   1      async active-low reset
//  clear_i     in   1      sync clear: empty buffer, go to LOAD
//  wr_valid_i  in   1      position write request
//  wr_pos_i    in   LOGW   real position; caller guarantees < N
//  wr_ready_o  out  1      write accepted when wr_valid_i & wr_ready_o
//  seal_i      in   1      end of real positions
//  rd_start_i  in   1      begin one streaming pass
//  rd_valid_o  out  1      rd_pos_o / rd_dummy_o / rd_last_o valid
//  rd_ready_i  in   1      consumer accepts the current entry
//  rd_pos_o    out  LOGW   streamed position
//  rd_dummy_o  out  1      entry is a dummy; the core discards its product
//  rd_last_o   out  1      final entry of the pass
//  count_o     out  LOGMW  real positions written
//  busy_o      out  1      high in PAD and STREAM
//  err_o       out  1      sticky protocol error
// BEHAVIOUR
//  Reset (async):
//   - State LOAD; all outputs 0, except wr_ready_o = 1 in LOAD.
//   - Counters 0; lfsr = SEED; memory contents undefined.
//  Storage: reg array of MAX_WEIGHT x (LOGW+1) bits {dummy, pos}; total = entries filled.
//  LFSR: 16-bit Galois, taps 0xB400. Advances only on (a) a PAD write and (b) accepted rd_start_i.
//  States:
//   LOAD:
//    - wr_ready_o = (total < MAX_WEIGHT).
//    - Accepted write stores {0, wr_pos_i} at index total; count_o++ and total++.
//    - seal_i goes to PAD if DUMMY_EN && total' < MAX_WEIGHT, else READY.
//    - total' includes a write in the same cycle; the write is taken first.
//   PAD:
//    - One entry per cycle: {1, d}.
//    - r = lfsr[LOGW-1:0]; d = (r >= N) ? r - N : r.
//    - Go to READY in the cycle total reaches MAX_WEIGHT.
//   READY:
//    - rd_start_i with total > 0 loads an offset and goes to STREAM.
//    - offset = lfsr[LOGMW-1:0] if < total, else 0.
//    - Sets idx = offset and remaining = total.
//    - rd_start_i with total == 0 sets err_o and stays in READY.
//   STREAM:
//    - Registered memory read; the first rd_valid_o is 1 cycle after rd_start_i.
//    - Output holds stable while rd_valid_o & !rd_ready_i.
//    - On each transfer: idx = (idx == total-1) ? 0 : idx+1 (wrap) and remaining--.
//    - Next entry is valid the following cycle; bubble-free streaming, 1 entry/cycle at rd_ready_i = 1.
//    - rd_last_o = (remaining == 1).
//    - Transfer with rd_last_o goes to READY with rd_valid_o = 0; the pass can be replayed.
//  Error (sticky) sets err_o for:
//   - wr_valid_i when total == MAX_WEIGHT in LOAD
//   - wr_valid_i or seal_i outside LOAD
//   - rd_start_i outside READY
//  Ignored operations: the offending request is dropped and state is unchanged.
//  clear_i:
//   - Highest priority in every state; takes effect next cycle.
//   - State LOAD; total = count_o = 0; rd_valid_o = 0; err_o = 0.
//   - LFSR is not reset, so dummy values differ across loads.
//  Async reset mid-PAD/STREAM aborts immediately; no partial state survives.
//  Edge cases:
//   - seal_i with count 0 and DUMMY_EN=1 gives an all-dummy set.
//   - DUMMY_EN=0 streams exactly count_o entries.
// TESTING
//  1 Reset; write 3,10,17668; seal -> PAD 72 cycles; MAX_WEIGHT=75 entries streamed.
//    Exactly 3 have rd_dummy_o=0 with values {3,10,17668}; every pos < 17669.
//    rd_last_o on the 75th transfer only.
//  2 Write 75 positions; 76th wr_valid_i -> wr_ready_o=0, err_o=1.
//    Seal goes directly to READY with no PAD.
//  3 Stream with rd_ready_i toggling 1,0,0,1...: output held during stalls.
//    No loss or duplication; the set equals the written set; the wrap from idx 74 to 0 is seen.
//  4 DUMMY_EN=0, write 5 and seal; start twice: each pass gives 5 entries, no dummies.
//    The two pass orders are rotations of the stored order.
//  5 clear_i asserted mid-STREAM -> next cycle rd_valid_o=0, count_o=0, err_o=0, wr_ready_o=1.
//  6 rst_n low mid-PAD -> outputs 0 asynchronously; after release, LFSR restarts at 16'hACE1.

Source files
------------

// File: rtl/sparse_pos_buffer_if.sv
// Handshake bundle between the position loader, sparse_pos_buffer and the multiplier core.
// The slave modport is the buffer side; the master modport is the controller/consumer side.
interface sparse_pos_buffer_if #(
    parameter int unsigned LOGW  = 15,
    parameter int unsigned LOGMW = 7
);
    logic             clear_i;
    logic             wr_valid_i;
    logic [LOGW-1:0]  wr_pos_i;
    logic             wr_ready_o;
    logic             seal_i;
    logic             rd_start_i;
    logic             rd_valid_o;
    logic             rd_ready_i;
    logic [LOGW-1:0]  rd_pos_o;
    logic             rd_dummy_o;
    logic             rd_last_o;
    logic [LOGMW-1:0] count_o;
    logic             busy_o;
    logic             err_o;

    modport master (
        output clear_i, wr_valid_i, wr_pos_i, seal_i, rd_start_i, rd_ready_i,
        input  wr_ready_o, rd_valid_o, rd_pos_o, rd_dummy_o, rd_last_o, count_o, busy_o, err_o
    );

    modport slave (
        input  clear_i, wr_valid_i, wr_pos_i, seal_i, rd_start_i, rd_ready_i,
        output wr_ready_o, rd_valid_o, rd_pos_o, rd_dummy_o, rd_last_o, count_o, busy_o, err_o
    );
endinterface

// File: rtl/sparse_pos_buffer.sv
// Position buffer for the sparse multiplier: loads real positions, pads with flagged LFSR
// dummies to a fixed weight, then streams the set from a pseudo-random rotation offset.
module sparse_pos_buffer #(
    parameter int unsigned MAX_WEIGHT = 75,
    parameter int unsigned N          = 17669,
    parameter int unsigned LOGW       = 15,
    parameter bit          DUMMY_EN   = 1'b1,
    parameter logic [15:0] SEED       = 16'hACE1,
    parameter int unsigned LOGMW      = $clog2(MAX_WEIGHT + 1)
) (
    input logic                clk,
    input logic                rst_n,
    sparse_pos_buffer_if.slave bus
);
    typedef enum logic [1:0] {LOAD, PAD, READY, STREAM} state_t;

    localparam logic [LOGMW-1:0] MW  = LOGMW'(MAX_WEIGHT);
    localparam logic [LOGW:0]    N_W = (LOGW + 1)'(N);

    state_t           state;
    logic [LOGW:0]    mem [MAX_WEIGHT];
    logic [LOGMW-1:0] total, count, idx, remaining;
    logic [15:0]      lfsr;
    logic             rd_valid, err;
    logic [LOGW:0]    rd_entry;

    logic [15:0]      lfsr_next;
    logic [LOGW:0]    rnd;
    logic [LOGW-1:0]  dummy_pos;
    logic             wr_acc, mem_we, xfer;
    logic [LOGW:0]    mem_wdata;
    logic [LOGMW-1:0] total_nxt, offset, idx_nxt;

    always_comb begin
        lfsr_next = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
        // Single conditional subtract folds [N, 2**LOGW) back into range since 2**LOGW <= 2*N.
        rnd       = {1'b0, lfsr[LOGW-1:0]};
        dummy_pos = (rnd >= N_W) ? LOGW'(rnd - N_W) : rnd[LOGW-1:0];
        wr_acc    = (state == LOAD) && bus.wr_valid_i && (total < MW) && !bus.clear_i;
        total_nxt = total + (wr_acc ? LOGMW'(1) : '0);
        mem_we    = wr_acc || ((state == PAD) && !bus.clear_i);
        mem_wdata = (state == PAD) ? {1'b1, dummy_pos} : {1'b0, bus.wr_pos_i};
        offset    = (lfsr[LOGMW-1:0] < total) ? lfsr[LOGMW-1:0] : '0;
        idx_nxt   = (idx == total - LOGMW'(1)) ? '0 : idx + LOGMW'(1);
        xfer      = rd_valid && bus.rd_ready_i;
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[total] <= mem_wdata;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= LOAD;
            total     <= '0;
            count     <= '0;
            idx       <= '0;
            remaining <= '0;
            lfsr      <= SEED;
            rd_valid  <= 1'b0;
            rd_entry  <= '0;
            err       <= 1'b0;
        end else if (bus.clear_i) begin
            state     <= LOAD;
            total     <= '0;
            count     <= '0;
            remaining <= '0;
            rd_valid  <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                LOAD: begin
                    if ((bus.wr_valid_i && (total == MW)) || bus.rd_start_i) err <= 1'b1;
                    if (wr_acc) begin
                        total <= total_nxt;
                        count <= count + LOGMW'(1);
                    end
                    if (bus.seal_i) state <= (DUMMY_EN && (total_nxt < MW)) ? PAD : READY;
                end
                PAD: begin
                    if (bus.wr_valid_i || bus.seal_i || bus.rd_start_i) err <= 1'b1;
                    lfsr  <= lfsr_next;
                    total <= total + LOGMW'(1);
                    if (total == MW - LOGMW'(1)) state <= READY;
                end
                READY: begin
                    if (bus.wr_valid_i || bus.seal_i) err <= 1'b1;
                    if (bus.rd_start_i) begin
                        if (total == '0) begin
                            err <= 1'b1;
                        end else begin
                            idx       <= offset;
                            remaining <= total;
                            rd_entry  <= mem[offset];
                            rd_valid  <= 1'b1;
                            lfsr      <= lfsr_next;
                            state     <= STREAM;
                        end
                    end
                end
                STREAM: begin
                    if (bus.wr_valid_i || bus.seal_i || bus.rd_start_i) err <= 1'b1;
                    if (xfer) begin
                        if (remaining == LOGMW'(1)) begin
                            rd_valid <= 1'b0;
                            state    <= READY;
                        end else begin
                            idx       <= idx_nxt;
                            remaining <= remaining - LOGMW'(1);
                            rd_entry  <= mem[idx_nxt];
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

    assign bus.wr_ready_o = (state == LOAD) && (total < MW);
    assign bus.rd_valid_o = rd_valid;
    assign bus.rd_pos_o   = rd_entry[LOGW-1:0];
    assign bus.rd_dummy_o = rd_valid && rd_entry[LOGW];
    assign bus.rd_last_o  = rd_valid && (remaining == LOGMW'(1));
    assign bus.count_o    = count;
    assign bus.busy_o     = (state == PAD) || (state == STREAM);
    assign bus.err_o      = err;
endmodule
